// File: rtl/zynq_axi3_pkg.sv
// Shared constants, enums and helpers for the AXI4 -> AXI3 burst splitter.
// Used by the top and by the per-channel burst generator.
package zynq_axi3_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE      = 4'b0011;
  localparam logic [1:0] AXI_LOCK       = 2'b00;
  localparam logic [3:0] AXI_QOS        = 4'b0000;
  localparam logic [2:0] AXI_PROT       = 3'b000;
  localparam int unsigned AXI3_MAX_LEN  = 16;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_AW,
    W_B,
    W_RESP
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_AR,
    R_DATA
  } r_state_e;

  function automatic logic [1:0] max_resp(
    input logic [1:0] a,
    input logic [1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/zynq_axi_burst_splitter.sv
// Turns one captured AXI4 burst into a run of <=16-beat AXI3 sub-bursts.
// Holds the running address, the beats still to issue and the sub-burst count.
module zynq_axi_burst_splitter
  import zynq_axi3_pkg::*;
#(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 64,
  parameter int id_width_p   = 6
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    load_i,
  input  logic [addr_width_p-1:0] addr_i,
  input  logic [7:0]              len_i,
  input  logic [id_width_p-1:0]   id_i,
  input  logic                    active_i,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic [addr_width_p-1:0] addr_o,
  output logic [3:0]              len_o,
  output logic [id_width_p-1:0]   id_o,
  output logic [4:0]              nsub_o,
  output logic                    done_o
);

  localparam logic [addr_width_p-1:0] step_lp =
    addr_width_p'(AXI3_MAX_LEN * (data_width_p / 8));

  logic [8:0] rem;
  logic       hs;

  assign valid_o = active_i;
  assign hs      = active_i & ready_i;
  assign len_o   = (rem >= 9'd16) ? 4'hF : 4'(rem - 9'd1);
  assign done_o  = hs & (rem <= 9'd16);

  // Capture a new burst, then advance one sub-burst per handshake.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      addr_o <= '0;
      rem    <= '0;
      id_o   <= '0;
      nsub_o <= '0;
    end else if (load_i) begin
      addr_o <= addr_i;
      rem    <= {1'b0, len_i} + 9'd1;
      id_o   <= id_i;
      nsub_o <= {1'b0, len_i[7:4]} + 5'd1;
    end else if (hs) begin
      addr_o <= addr_o + step_lp;
      rem    <= (rem > 9'd16) ? rem - 9'd16 : '0;
    end
  end

endmodule

// File: rtl/zynq_axi4_to_axi3_splitter.sv
// AXI4 master to Zynq HP (AXI3) bridge: splits long INCR bursts into
// 16-beat pieces, rebuilds wlast/wid, merges B and gates rlast.
module zynq_axi4_to_axi3_splitter
  import zynq_axi3_pkg::*;
#(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 64,
  parameter int id_width_p   = 6
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [addr_width_p-1:0]   s_awaddr,
  input  logic [7:0]                s_awlen,
  input  logic [id_width_p-1:0]     s_awid,
  input  logic                      s_awvalid,
  output logic                      s_awready,
  input  logic [data_width_p-1:0]   s_wdata,
  input  logic [data_width_p/8-1:0] s_wstrb,
  input  logic                      s_wlast,
  input  logic                      s_wvalid,
  output logic                      s_wready,
  output logic [id_width_p-1:0]     s_bid,
  output logic [1:0]                s_bresp,
  output logic                      s_bvalid,
  input  logic                      s_bready,
  input  logic [addr_width_p-1:0]   s_araddr,
  input  logic [7:0]                s_arlen,
  input  logic [id_width_p-1:0]     s_arid,
  input  logic                      s_arvalid,
  output logic                      s_arready,
  output logic [data_width_p-1:0]   s_rdata,
  output logic [id_width_p-1:0]     s_rid,
  output logic [1:0]                s_rresp,
  output logic                      s_rlast,
  output logic                      s_rvalid,
  input  logic                      s_rready,
  output logic [addr_width_p-1:0]   m_awaddr,
  output logic [3:0]                m_awlen,
  output logic [id_width_p-1:0]     m_awid,
  output logic                      m_awvalid,
  output logic [1:0]                m_awlock,
  output logic [3:0]                m_awcache,
  output logic [2:0]                m_awprot,
  output logic [2:0]                m_awsize,
  output logic [1:0]                m_awburst,
  output logic [3:0]                m_awqos,
  input  logic                      m_awready,
  output logic [data_width_p-1:0]   m_wdata,
  output logic [data_width_p/8-1:0] m_wstrb,
  output logic [id_width_p-1:0]     m_wid,
  output logic                      m_wlast,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [id_width_p-1:0]     m_bid,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [addr_width_p-1:0]   m_araddr,
  output logic [3:0]                m_arlen,
  output logic [id_width_p-1:0]     m_arid,
  output logic                      m_arvalid,
  output logic [1:0]                m_arlock,
  output logic [3:0]                m_arcache,
  output logic [2:0]                m_arprot,
  output logic [2:0]                m_arsize,
  output logic [1:0]                m_arburst,
  output logic [3:0]                m_arqos,
  input  logic                      m_arready,
  input  logic [data_width_p-1:0]   m_rdata,
  input  logic [id_width_p-1:0]     m_rid,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rlast,
  input  logic                      m_rvalid,
  output logic                      m_rready
);

  localparam int size_lp = $clog2(data_width_p / 8);

  w_state_e  w_state, w_next;
  r_state_e  r_state, r_next;
  logic      aw_load, aw_done, ar_load, ar_done;
  logic [4:0] aw_nsub, ar_nsub, bcnt, bcnt_next, rcnt;
  logic [8:0] wleft;
  logic [3:0] widx;
  axi_resp_e worst_resp;
  logic      w_pass, w_hs, b_hs, r_pass, r_hs, r_final, r_lastsub;
  logic      unused_ok;

  assign unused_ok = &{1'b0, s_wlast, m_bid};

  assign m_awlock  = AXI_LOCK;
  assign m_awcache = AXI_CACHE;
  assign m_awprot  = AXI_PROT;
  assign m_awsize  = 3'(size_lp);
  assign m_awburst = AXI_BURST_INCR;
  assign m_awqos   = AXI_QOS;
  assign m_arlock  = AXI_LOCK;
  assign m_arcache = AXI_CACHE;
  assign m_arprot  = AXI_PROT;
  assign m_arsize  = 3'(size_lp);
  assign m_arburst = AXI_BURST_INCR;
  assign m_arqos   = AXI_QOS;

  assign s_awready = (w_state == W_IDLE) & ~reset_i;
  assign aw_load   = s_awvalid & s_awready;
  assign s_arready = (r_state == R_IDLE) & ~reset_i;
  assign ar_load   = s_arvalid & s_arready;

  zynq_axi_burst_splitter #(
    .addr_width_p(addr_width_p),
    .data_width_p(data_width_p),
    .id_width_p  (id_width_p)
  ) aw_split (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (aw_load),
    .addr_i  (s_awaddr),
    .len_i   (s_awlen),
    .id_i    (s_awid),
    .active_i(w_state == W_AW),
    .ready_i (m_awready),
    .valid_o (m_awvalid),
    .addr_o  (m_awaddr),
    .len_o   (m_awlen),
    .id_o    (m_awid),
    .nsub_o  (aw_nsub),
    .done_o  (aw_done)
  );

  zynq_axi_burst_splitter #(
    .addr_width_p(addr_width_p),
    .data_width_p(data_width_p),
    .id_width_p  (id_width_p)
  ) ar_split (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (ar_load),
    .addr_i  (s_araddr),
    .len_i   (s_arlen),
    .id_i    (s_arid),
    .active_i(r_state == R_AR),
    .ready_i (m_arready),
    .valid_o (m_arvalid),
    .addr_o  (m_araddr),
    .len_o   (m_arlen),
    .id_o    (m_arid),
    .nsub_o  (ar_nsub),
    .done_o  (ar_done)
  );

  assign w_pass   = ((w_state == W_AW) | (w_state == W_B)) & (wleft != 9'd0);
  assign m_wvalid = w_pass & s_wvalid;
  assign s_wready = w_pass & m_wready;
  assign w_hs     = m_wvalid & m_wready;
  assign m_wdata  = s_wdata;
  assign m_wstrb  = s_wstrb;
  assign m_wid    = m_awid;
  assign m_wlast  = (widx == 4'hF) | (wleft == 9'd1);

  assign m_bready  = (w_state == W_AW) | (w_state == W_B);
  assign b_hs      = m_bvalid & m_bready;
  assign bcnt_next = bcnt + 5'(b_hs);
  assign s_bvalid  = (w_state == W_RESP);
  assign s_bid     = m_awid;
  assign s_bresp   = worst_resp;

  // Write sequencing: issue sub-AWs, collect every B, return one merged B.
  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE: if (aw_load) w_next = W_AW;
      W_AW:   if (aw_done) w_next = W_B;
      W_B:    if (bcnt_next == aw_nsub) w_next = W_RESP;
      W_RESP: if (s_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Write state plus beat, group and response bookkeeping.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      w_state    <= W_IDLE;
      wleft      <= '0;
      widx       <= '0;
      bcnt       <= '0;
      worst_resp <= RESP_OKAY;
    end else begin
      w_state <= w_next;
      if (aw_load) begin
        wleft      <= {1'b0, s_awlen} + 9'd1;
        widx       <= '0;
        bcnt       <= '0;
        worst_resp <= RESP_OKAY;
      end else begin
        if (w_hs) begin
          wleft <= wleft - 9'd1;
          widx  <= widx + 4'd1;
        end
        if (b_hs) begin
          bcnt       <= bcnt_next;
          worst_resp <= axi_resp_e'(max_resp(worst_resp, m_bresp));
        end
      end
    end
  end

  assign r_pass    = (r_state != R_IDLE);
  assign s_rvalid  = r_pass & m_rvalid;
  assign m_rready  = r_pass & s_rready;
  assign r_hs      = m_rvalid & m_rready;
  assign s_rdata   = m_rdata;
  assign s_rid     = m_rid;
  assign s_rresp   = m_rresp;
  assign r_lastsub = (rcnt == ar_nsub - 5'd1);
  assign s_rlast   = m_rlast & r_lastsub;
  assign r_final   = r_hs & m_rlast & r_lastsub;

  // Read sequencing: issue sub-ARs, finish on the last sub-burst's rlast.
  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE: if (ar_load) r_next = R_AR;
      R_AR:   if (ar_done) r_next = R_DATA;
      R_DATA: if (r_final) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read state and count of completed sub-bursts.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= R_IDLE;
      rcnt    <= '0;
    end else begin
      r_state <= r_next;
      if (ar_load) rcnt <= '0;
      else if (r_hs & m_rlast) rcnt <= rcnt + 5'd1;
    end
  end

  // Upstream promises no burst crosses a 4 KB page.
  always_ff @(posedge clk_i) begin
    if (!reset_i && aw_load)
      assert ({4'd0, s_awaddr[11:0]} + (({8'd0, s_awlen} + 16'd1) << size_lp)
              <= 16'h1000);
    if (!reset_i && ar_load)
      assert ({4'd0, s_araddr[11:0]} + (({8'd0, s_arlen} + 16'd1) << size_lp)
              <= 16'h1000);
  end

endmodule

// File: tb/tb_zynq_axi4_to_axi3_splitter.sv
// Bench for the AXI4 -> AXI3 splitter: random traffic and backpressure,
// compared against a burst-level model of the expected AXI3 traffic.
module tb_zynq_axi4_to_axi3_splitter;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 6;
  localparam int SW = DW / 8;
  localparam int LIMIT = 20000;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  logic [AW-1:0] s_awaddr, s_araddr, m_awaddr, m_araddr;
  logic [7:0]    s_awlen, s_arlen;
  logic [IW-1:0] s_awid, s_arid, s_bid, s_rid, m_awid, m_wid, m_bid;
  logic [IW-1:0] m_arid, m_rid;
  logic s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
  logic s_bvalid, s_bready, s_arvalid, s_arready;
  logic s_rlast, s_rvalid, s_rready;
  logic [DW-1:0] s_wdata, s_rdata, m_wdata, m_rdata;
  logic [SW-1:0] s_wstrb, m_wstrb;
  logic [1:0]    s_bresp, s_rresp, m_bresp, m_rresp;
  logic [3:0]    m_awlen, m_arlen, m_awcache, m_arcache, m_awqos, m_arqos;
  logic [1:0]    m_awlock, m_arlock, m_awburst, m_arburst;
  logic [2:0]    m_awprot, m_arprot, m_awsize, m_arsize;
  logic m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
  logic m_bvalid, m_bready, m_arvalid, m_arready;
  logic m_rlast, m_rvalid, m_rready;

  zynq_axi4_to_axi3_splitter dut (
    .clk_i(clk), .reset_i(reset_i),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awid(s_awid),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
    .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arid(s_arid),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rid(s_rid), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awid(m_awid),
    .m_awvalid(m_awvalid), .m_awlock(m_awlock), .m_awcache(m_awcache),
    .m_awprot(m_awprot), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awqos(m_awqos), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wid(m_wid),
    .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
    .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arid(m_arid),
    .m_arvalid(m_arvalid), .m_arlock(m_arlock), .m_arcache(m_arcache),
    .m_arprot(m_arprot), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arqos(m_arqos), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rid(m_rid), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [IW-1:0] id;
  } cmd_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [3:0]    len;
    logic [IW-1:0] id;
  } sub_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } beat_t;

  cmd_t  mw_aw_q[$], mr_ar_q[$];
  beat_t mw_w_q[$], sent_w[$];
  sub_t  aw_log[$], ar_log[$];
  beat_t w_log[$], r_q[$], r_exp[$], r_log[$], b_log[$];
  logic [1:0] bresp_tab[16];
  int slave_wlast, b_issued;
  bit bus_en, bp;
  int checks, failures;

  function automatic logic rnd_rdy();
    return bp ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  task automatic idle_inputs();
    s_awvalid = 0; s_wvalid = 0; s_bready = 0; s_arvalid = 0;
    s_rready = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
    m_arready = 0; m_rvalid = 0;
    s_awaddr = '0; s_awlen = '0; s_awid = '0; s_wdata = '0;
    s_wstrb = '0; s_wlast = 0; s_araddr = '0; s_arlen = '0;
    s_arid = '0; m_bid = '0; m_bresp = '0; m_rdata = '0;
    m_rid = '0; m_rresp = '0; m_rlast = 0;
  endtask

  task automatic clear_logs();
    mw_aw_q.delete(); mr_ar_q.delete(); mw_w_q.delete();
    sent_w.delete(); aw_log.delete(); ar_log.delete();
    w_log.delete(); r_q.delete(); r_exp.delete();
    r_log.delete(); b_log.delete();
    slave_wlast = 0; b_issued = 0;
  endtask

  // Bus agent: upstream master and downstream HP slave, one step per cycle.
  initial begin
    beat_t bt;
    int    ready_b;
    forever begin
      @(negedge clk);
      if (!bus_en) begin
        idle_inputs();
      end else begin
        s_awvalid = (mw_aw_q.size() > 0);
        if (s_awvalid) begin
          s_awaddr = mw_aw_q[0].addr;
          s_awlen  = mw_aw_q[0].len;
          s_awid   = mw_aw_q[0].id;
        end
        s_wvalid = (mw_w_q.size() > 0);
        if (s_wvalid) begin
          s_wdata = mw_w_q[0].data;
          s_wstrb = mw_w_q[0].strb;
          s_wlast = mw_w_q[0].last;
        end
        s_arvalid = (mr_ar_q.size() > 0);
        if (s_arvalid) begin
          s_araddr = mr_ar_q[0].addr;
          s_arlen  = mr_ar_q[0].len;
          s_arid   = mr_ar_q[0].id;
        end
        ready_b = (aw_log.size() < slave_wlast) ? aw_log.size() : slave_wlast;
        m_bvalid = (ready_b > b_issued);
        m_bid    = m_bvalid ? aw_log[b_issued].id : '0;
        m_bresp  = (m_bvalid && b_issued < 16) ? bresp_tab[b_issued] : 2'b00;
        m_rvalid = (r_q.size() > 0);
        if (m_rvalid) begin
          m_rdata = r_q[0].data;
          m_rid   = r_q[0].id;
          m_rresp = r_q[0].resp;
          m_rlast = r_q[0].last;
        end
        s_bready  = rnd_rdy();
        s_rready  = rnd_rdy();
        m_awready = rnd_rdy();
        m_wready  = rnd_rdy();
        m_arready = rnd_rdy();
        #1;
        if (s_awvalid && s_awready) void'(mw_aw_q.pop_front());
        if (s_wvalid && s_wready) void'(mw_w_q.pop_front());
        if (s_arvalid && s_arready) void'(mr_ar_q.pop_front());
        if (m_awvalid && m_awready)
          aw_log.push_back('{m_awaddr, m_awlen, m_awid});
        if (m_wvalid && m_wready) begin
          w_log.push_back('{m_wdata, m_wstrb, m_wlast, m_wid, 2'b00});
          if (m_wlast) slave_wlast++;
        end
        if (m_bvalid && m_bready) b_issued++;
        if (s_bvalid && s_bready)
          b_log.push_back('{'0, '0, 1'b0, s_bid, s_bresp});
        if (m_arvalid && m_arready) begin
          ar_log.push_back('{m_araddr, m_arlen, m_arid});
          for (int j = 0; j <= int'(m_arlen); j++) begin
            bt.data = {$urandom, $urandom};
            bt.strb = '0;
            bt.last = (j == int'(m_arlen));
            bt.id   = m_arid;
            bt.resp = 2'($urandom_range(0, 3));
            r_q.push_back(bt);
            r_exp.push_back(bt);
          end
        end
        if (m_rvalid && m_rready) void'(r_q.pop_front());
        if (s_rvalid && s_rready)
          r_log.push_back('{s_rdata, '0, s_rlast, s_rid, s_rresp});
      end
    end
  end

  task automatic test_reset();
    bus_en = 0;
    idle_inputs();
    reset_i = 0;
    #1 reset_i = 1;
    s_awvalid = 1; s_wvalid = 1; s_arvalid = 1; m_rvalid = 1; m_bvalid = 1;
    #2;
    checks++;
    if ({m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid,
         s_awready, s_arready} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0",
               {m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid,
                s_awready, s_arready});
    end
    idle_inputs();
    repeat (2) @(negedge clk);
    reset_i = 0;
    #1;
    checks++;
    if ({s_awready, s_arready, m_bready} !== 3'b110) begin
      failures++;
      $display("FAIL idle_readies got=%b exp=110",
               {s_awready, s_arready, m_bready});
    end
    clear_logs();
    bus_en = 1;
    repeat (2) @(posedge clk);
  endtask

  // One write and/or one read burst, checked against a burst-level model.
  task automatic test_transfer(
    input string     tag,
    input bit        do_w,
    input [AW-1:0]   waddr,
    input [7:0]      wlen,
    input [IW-1:0]   wid,
    input bit        do_r,
    input [AW-1:0]   raddr,
    input [7:0]      rlen,
    input [IW-1:0]   rid,
    input bit        use_bp
  );
    int nw, nr, nsw, nsr, c, rem;
    logic [1:0] eresp;
    beat_t bt;
    @(posedge clk);
    clear_logs();
    bp  = use_bp;
    nw  = int'(wlen) + 1;
    nr  = int'(rlen) + 1;
    nsw = (nw + 15) / 16;
    nsr = (nr + 15) / 16;
    if (do_w) begin
      for (int i = 0; i < nw; i++) begin
        bt.data = {$urandom, $urandom};
        bt.strb = SW'($urandom);
        bt.last = 1'($urandom);
        bt.id   = '0;
        bt.resp = '0;
        sent_w.push_back(bt);
        mw_w_q.push_back(bt);
      end
      mw_aw_q.push_back('{waddr, wlen, wid});
    end
    if (do_r) mr_ar_q.push_back('{raddr, rlen, rid});
    c = 0;
    while (((do_w && b_log.size() < 1) || (do_r && r_log.size() < nr))
           && c < LIMIT) begin
      @(posedge clk);
      c++;
    end
    repeat (8) @(posedge clk);
    checks++;
    if (c >= LIMIT) begin
      failures++;
      $display("FAIL %s timeout got_b=%0d got_r=%0d exp_r=%0d",
               tag, b_log.size(), r_log.size(), nr);
    end
    if (do_w) begin
      checks++;
      if (aw_log.size() != nsw) begin
        failures++;
        $display("FAIL %s aw_count got=%0d exp=%0d", tag, aw_log.size(), nsw);
      end
      rem = nw;
      for (int k = 0; k < nsw && k < aw_log.size(); k++) begin
        checks++;
        if (aw_log[k].addr !== waddr + AW'(k * 128) ||
            aw_log[k].len !== 4'(((rem > 16) ? 16 : rem) - 1) ||
            aw_log[k].id !== wid) begin
          failures++;
          $display("FAIL %s aw%0d got=%h/%0d/%0d exp=%h/%0d/%0d", tag, k,
                   aw_log[k].addr, aw_log[k].len, aw_log[k].id,
                   waddr + AW'(k * 128), ((rem > 16) ? 16 : rem) - 1, wid);
        end
        rem -= 16;
      end
      checks++;
      if (w_log.size() != nw) begin
        failures++;
        $display("FAIL %s w_count got=%0d exp=%0d", tag, w_log.size(), nw);
      end
      for (int i = 0; i < nw && i < w_log.size(); i++) begin
        checks++;
        if (w_log[i].data !== sent_w[i].data ||
            w_log[i].strb !== sent_w[i].strb ||
            w_log[i].last !== ((i % 16 == 15) || (i == nw - 1)) ||
            w_log[i].id !== wid) begin
          failures++;
          $display("FAIL %s w%0d got=%h/%h/%b/%0d exp=%h/%h/%b/%0d", tag, i,
                   w_log[i].data, w_log[i].strb, w_log[i].last, w_log[i].id,
                   sent_w[i].data, sent_w[i].strb,
                   (i % 16 == 15) || (i == nw - 1), wid);
        end
      end
      eresp = 2'b00;
      for (int k = 0; k < nsw; k++)
        if (bresp_tab[k] > eresp) eresp = bresp_tab[k];
      checks++;
      if (b_log.size() != 1) begin
        failures++;
        $display("FAIL %s b_count got=%0d exp=1", tag, b_log.size());
      end else begin
        checks++;
        if (b_log[0].resp !== eresp || b_log[0].id !== wid) begin
          failures++;
          $display("FAIL %s b got=%0d/%0d exp=%0d/%0d", tag,
                   b_log[0].resp, b_log[0].id, eresp, wid);
        end
      end
    end
    if (do_r) begin
      checks++;
      if (ar_log.size() != nsr) begin
        failures++;
        $display("FAIL %s ar_count got=%0d exp=%0d", tag, ar_log.size(), nsr);
      end
      rem = nr;
      for (int k = 0; k < nsr && k < ar_log.size(); k++) begin
        checks++;
        if (ar_log[k].addr !== raddr + AW'(k * 128) ||
            ar_log[k].len !== 4'(((rem > 16) ? 16 : rem) - 1) ||
            ar_log[k].id !== rid) begin
          failures++;
          $display("FAIL %s ar%0d got=%h/%0d/%0d exp=%h/%0d/%0d", tag, k,
                   ar_log[k].addr, ar_log[k].len, ar_log[k].id,
                   raddr + AW'(k * 128), ((rem > 16) ? 16 : rem) - 1, rid);
        end
        rem -= 16;
      end
      checks++;
      if (r_log.size() != nr) begin
        failures++;
        $display("FAIL %s r_count got=%0d exp=%0d", tag, r_log.size(), nr);
      end
      for (int i = 0; i < nr && i < r_log.size() && i < r_exp.size(); i++) begin
        checks++;
        if (r_log[i].data !== r_exp[i].data ||
            r_log[i].resp !== r_exp[i].resp ||
            r_log[i].last !== (i == nr - 1) ||
            r_log[i].id !== rid) begin
          failures++;
          $display("FAIL %s r%0d got=%h/%0d/%b/%0d exp=%h/%0d/%b/%0d", tag, i,
                   r_log[i].data, r_log[i].resp, r_log[i].last, r_log[i].id,
                   r_exp[i].data, r_exp[i].resp, i == nr - 1, rid);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] wa, ra;
    logic [7:0] wl, rl;
    for (int it = 0; it < 8; it++) begin
      wl = (it < 4) ? 8'd31 : 8'($urandom_range(0, 255));
      rl = (it < 4) ? 8'd31 : 8'($urandom_range(0, 255));
      wa = ($urandom & 32'hFFFF_F000) +
           AW'($urandom_range(0, (4096 - (int'(wl) + 1) * 8) / 8) * 8);
      ra = ($urandom & 32'hFFFF_F000) +
           AW'($urandom_range(0, (4096 - (int'(rl) + 1) * 8) / 8) * 8);
      for (int k = 0; k < 16; k++) bresp_tab[k] = 2'($urandom_range(0, 3));
      test_transfer("concurrent", 1, wa, wl, IW'($urandom), 1, ra, rl,
                    IW'($urandom), 1);
    end
  endtask

  task automatic test_reset_mid_write();
    int c;
    for (int k = 0; k < 16; k++) bresp_tab[k] = 2'b00;
    @(posedge clk);
    clear_logs();
    bp = 0;
    for (int i = 0; i < 256; i++)
      mw_w_q.push_back('{{$urandom, $urandom}, '1, 1'b0, '0, '0});
    mw_aw_q.push_back('{32'h0000_3000, 8'd255, 6'd9});
    c = 0;
    while (aw_log.size() < 2 && c < LIMIT) begin
      @(posedge clk);
      c++;
    end
    checks++;
    if (c >= LIMIT) begin
      failures++;
      $display("FAIL rst_mid wait_aw got=%0d exp=2", aw_log.size());
    end
    bus_en = 0;
    @(negedge clk);
    #1;
    reset_i = 1;
    s_awvalid = 1; s_wvalid = 1; s_arvalid = 1; m_rvalid = 1; m_bvalid = 1;
    #1;
    checks++;
    if ({m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid,
         s_awready, s_arready} !== 7'b0) begin
      failures++;
      $display("FAIL rst_mid outputs got=%b exp=0",
               {m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid,
                s_awready, s_arready});
    end
    clear_logs();
    @(negedge clk);
    #1;
    reset_i = 0;
    idle_inputs();
    bus_en = 1;
    test_transfer("after_reset", 1, 32'h0000_3000, 8'd3, 6'd12,
                  0, '0, 8'd0, '0, 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    bp = 0;
    for (int k = 0; k < 16; k++) bresp_tab[k] = 2'b00;
    test_reset();
    test_transfer("wr_len0", 1, 32'h0000_1000, 8'd0, 6'd5,
                  0, '0, 8'd0, '0, 0);
    test_transfer("wr_len16", 1, 32'h0000_1000, 8'd16, 6'd33,
                  0, '0, 8'd0, '0, 0);
    bresp_tab[7] = 2'b10;
    test_transfer("wr_len255", 1, 32'h0000_1000, 8'd255, 6'd63,
                  0, '0, 8'd0, '0, 0);
    bresp_tab[7] = 2'b00;
    test_transfer("rd_len40", 0, '0, 8'd0, '0,
                  1, 32'h0000_2000, 8'd40, 6'd17, 0);
    test_back_to_back();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zynq_axi4_to_axi3_splitter.md
Name: zynq_axi4_to_axi3_splitter

Overview:
Sits directly downstream of the black-parrot top_zynq m00_axi master and upstream of the Zynq HP slave port.
- The master side produces AXI4 INCR bursts with an 8-bit len, as emitted by bsg_cache_to_axi. The HP port accepts only AXI3 bursts: 4-bit len, 2-bit lock, wid.
- The block splits each AXI4 burst into up to 16 AXI3 sub-bursts of at most 16 beats each.
- It regenerates wlast/wid, merges the sub-burst write responses into one B, and presents a single rlast to the master.
- One write and one read transaction are in flight at a time; the two paths are independent.

Parameters:
addr_width_p, 32, AXI address width
data_width_p, 64, AXI data width; every beat is full width
id_width_p, 6, AXI ID width (awid/arid/wid/bid/rid)

Ports:
clk_i  in  1  single clock for all channels
reset_i  in  1  asynchronous, active-high reset
s_aw{addr,len,id,valid} / s_awready  in/out  addr_width_p,8,id_width_p,1 / 1  upstream AXI4 write address channel
s_w{data,strb,last,valid} / s_wready  in/out  data_width_p,data_width_p/8,1,1 / 1  upstream write data channel
s_b{id,resp,valid} / s_bready  out/in  id_width_p,2,1 / 1  upstream write response channel
s_ar{addr,len,id,valid} / s_arready  in/out  addr_width_p,8,id_width_p,1 / 1  upstream read address channel
s_r{data,id,resp,last,valid} / s_rready  out/in  data_width_p,id_width_p,2,1,1 / 1  upstream read data channel
m_aw{addr,len,id,valid,lock,cache,prot,size,burst,qos} / m_awready  out/in  addr_width_p,4,id_width_p,1,2,4,3,3,2,4 / 1  AXI3 write address channel
m_w{data,strb,id,last,valid} / m_wready  out/in  data_width_p,data_width_p/8,id_width_p,1,1 / 1  AXI3 write data channel
m_b{id,resp,valid} / m_bready  in/out  id_width_p,2,1 / 1  AXI3 write response channel
m_ar{addr,len,id,valid,lock,cache,prot,size,burst,qos} / m_arready  out/in  same widths as m_aw  AXI3 read address channel
m_r{data,id,resp,last,valid} / m_rready  in/out  data_width_p,id_width_p,2,1,1 / 1  AXI3 read data channel

Behaviour:
Constant outputs:
- burst=2'b01 (INCR), size=log2(data_width_p/8), lock=0, cache=4'b0011, prot=0, qos=0.

Reset (asynchronous) and its effects:
- Both FSMs go to IDLE and all counters clear.
- All m_*valid and s_bvalid/s_rvalid are 0; s_awready/s_arready are 0 while reset_i=1.
- Asserting reset mid-burst abandons the transaction silently. Quiescing the HP port first is the system's responsibility.

Write FSM: W_IDLE -> W_AW -> W_B -> W_RESP -> W_IDLE
- W_IDLE: s_awready=1. On handshake, register addr, id, rem=len+1 (9 bits), nsub=ceil((len+1)/16); clear bcnt, worst_resp and the beat counter.
- W_AW: m_awvalid=1, m_awaddr=cur_addr, m_awlen=min(rem,16)-1, m_awid=id.
  - Each handshake: cur_addr += 16*(data_width_p/8), rem -= 16 (saturating at 0).
  - The handshake that issues the last sub-burst goes to W_B.
- W data: passthrough (data, strb, valid/ready) in W_AW and W_B only while beats remain. s_wready=0 otherwise.
  - m_wid=id.
  - m_wlast=1 on beat 15 of each 16-beat group and on the final beat. s_wlast is ignored.
  - W beats may lead their AW; the HP port accepts this ordering.
- B channel: m_bready=1 in W_AW and W_B, 0 in W_RESP.
  - Each m_b handshake: bcnt++, worst_resp=max(worst_resp, m_bresp).
  - W_B goes to W_RESP when bcnt==nsub, counting a handshake in that same cycle.
- W_RESP: s_bvalid=1, s_bid=id, s_bresp=worst_resp. On s_bready go to W_IDLE.
- len=255: 16 sub-bursts; the 9-bit rem must not wrap.

Read FSM: R_IDLE -> R_AR -> R_DATA -> R_IDLE
- R_IDLE: s_arready=1; capture as for writes.
- R_AR: issues sub-ARs exactly like W_AW. R beats already flow during this state.
- R channel: pure passthrough in R_AR/R_DATA: s_rvalid=m_rvalid, m_rready=s_rready, data/id/resp unchanged.
- s_rlast = m_rlast && (rcnt==nsub-1), where rcnt counts m_rlast handshakes.
- The final-rlast handshake returns to R_IDLE. This occurs only once all ARs have issued.
- Simultaneous final-rlast handshake and new s_ar valid: the new AR is accepted on the next cycle (one IDLE cycle).

Boundary rules:
- Upstream guarantees no 4 KB crossing and size equal to full width. These are checked by assertion only.

Decomposition:
- zynq_axi3_pkg holds:
  - constants: INCR burst, cache, lock, qos, prot and the max AXI3 length (16);
  - axi_resp_e enum (OKAY/EXOKAY/SLVERR/DECERR);
  - function max_resp.
- Natural sub-module: zynq_axi_burst_splitter, holding the address/remaining/sub-count generator plus its handshake. Instantiated twice (AW and AR).
- W-last regeneration, B merge and R-last gating stay in the top.

Test Plan:
- Write awaddr=0x1000, len=0, OKAY -> one AW (addr 0x1000, len 0), one W with wlast=1, s_bresp=0 after 1 B.
- Write len=16 at 0x1000 -> AWs (0x1000, len 15), (0x1080, len 0); wlast on beats 15 and 16; single s_b after 2nd B.
- Write len=255 with m_bresp=2'b10 on sub-burst 7 only -> 16 AWs, addresses step 0x80; s_bresp=2'b10.
- Read araddr=0x2000, len=40 -> ARs len 15, 15, 8 at 0x2000/0x2080/0x2100; s_rlast only on beat 41; rresp passed per beat.
- Random m_awready/m_wready/m_rready/s_rready/s_bready backpressure, concurrent read+write of len 31 -> data order preserved, no lost or duplicated beats.
- reset_i pulsed mid-write (after 2nd AW) -> all valids 0 within the reset cycle; next write of len=3 completes normally.
